// File: rtl/key_uart_pkg.sv
// Shared definitions for the key_event_uart block: TX state encoding,
// frame constants and width helpers used by the top and by key_debounce.
package key_uart_pkg;

    localparam int         DATA_BITS         = 8;
    localparam logic [7:0] CHAR_BASE_DEFAULT = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Counter/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key input: 2-flop synchroniser, mismatch counter and debounced level.
// Emits a single-cycle pulse on every accepted 0->1 change of the level.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   key_in  in  raw key level (1 = pressed), asynchronous to clk
//   press   out one-cycle pulse when the debounced level rises
module key_debounce
    import key_uart_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press
);

    localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q,   deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        // The counter only advances while the synced level disagrees with the
        // accepted level; any agreement restarts the stability window.
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = deb_d & ~deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/key_event_uart.sv
// N-key press reporter: debounced key presses become ASCII bytes
// (CHAR_BASE + key index), queued in a small FIFO and sent on a UART TX line.
// Default frame is 8N1; defining KEY_UART_PARITY_EN adds an even-parity bit
// after D7 (8E1).
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   key_in    in  raw key levels, 1 = pressed, asynchronous
//   tx        out UART serial line, idle high (registered)
//   tx_valid  out high from first start-bit cycle to last stop-bit cycle
//   overflow  out sticky: a press was dropped on a full FIFO
module key_event_uart
    import key_uart_pkg::*;
#(
    parameter int         NUM_KEYS        = 4,
    parameter int         CLK_HZ          = 50_000_000,
    parameter int         BAUD            = 115200,
    parameter int         DEBOUNCE_CYCLES = 500_000,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] CHAR_BASE       = CHAR_BASE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                tx,
    output logic                tx_valid,
    output logic                overflow
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int BAUD_W   = clog2_min1(BAUD_DIV);
    localparam int PTR_W    = clog2_min1(FIFO_DEPTH);
    localparam int KEY_W    = clog2_min1(NUM_KEYS);
    localparam int BIT_W    = clog2_min1(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    // ---------------- key synchronise / debounce ----------------
    logic [NUM_KEYS-1:0] press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_in (key_in[k]),
            .press  (press[k])
        );
    end

    // ---------------- pending flags / arbiter ----------------
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] grant;
    logic                arb_valid;
    logic [KEY_W-1:0]    arb_sel;
    logic [7:0]          push_byte;

    always_comb begin
        arb_sel = '0;
        // Descending scan so the lowest pending index wins.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                arb_sel = KEY_W'(i);
            end
        end
        arb_valid = |pending_q;
        grant     = pending_q & (~pending_q + 1'b1);
        push_byte = CHAR_BASE + 8'(arb_sel);
        pending_d = (pending_q & ~grant) | press;
    end

    // ---------------- event FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop, drop;
    logic [7:0]       rd_data;
    logic             overflow_q, overflow_d;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        rd_data    = mem_q[rd_ptr_q];
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push       = arb_valid && (!fifo_full || pop);
        drop       = arb_valid && fifo_full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [7:0]        data_q,  data_d;
    logic              tx_q,    tx_d;
    logic              tx_valid_q, tx_valid_d;
    logic              bit_done;

    assign bit_done = (baud_q == BAUD_LAST);

    // Next-state logic; the FIFO pop is tied to entering START.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && bit_q == BIT_LAST) begin
`ifdef KEY_UART_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef KEY_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit timing and shift data. The baud counter restarts on every state
    // entry and at every data-bit boundary.
    always_comb begin
        data_d = pop ? rd_data : data_q;
        if (state_d == ST_IDLE || state_d != state_q || bit_done) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
        if (state_d != ST_DATA) begin
            bit_d = '0;
        end else if (state_q == ST_DATA && bit_done) begin
            bit_d = bit_q + 1'b1;
        end else begin
            bit_d = bit_q;
        end
    end

    // Outputs are decoded from the next state so the registered line is
    // aligned with the state register.
    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_d];
`ifdef KEY_UART_PARITY_EN
            ST_PARITY: tx_d = ^data_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            tx_valid_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign tx       = tx_q;
    assign tx_valid = tx_valid_q;
    assign overflow = overflow_q;

endmodule
